// File: rtl/nt_hop_selector_pkg.sv
// Package nt_pkg: shared types and constants for the neighbor-table hop selector.
//   - nt_state_t : scan FSM states
//   - nt_entry_t : one neighbor-table entry {id, hops, q, energy}
//   - nt_best_t  : running best candidate {id, hops, q, valid}
package nt_pkg;

    localparam int unsigned WORD_WIDTH    = 16;
    localparam int unsigned MAX_NEIGHBORS = 16;
    localparam int unsigned ADDR_WIDTH    = $clog2(MAX_NEIGHBORS);

    localparam logic [WORD_WIDTH-1:0] ENERGY_FLOOR = 16'h0010;
    localparam logic [WORD_WIDTH-1:0] NO_NODE      = 16'hFFFF;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_DRAIN,
        S_DONE
    } nt_state_t;

    typedef struct packed {
        logic [WORD_WIDTH-1:0] id;
        logic [WORD_WIDTH-1:0] hops;
        logic [WORD_WIDTH-1:0] q;
        logic [WORD_WIDTH-1:0] energy;
    } nt_entry_t;

    typedef struct packed {
        logic [WORD_WIDTH-1:0] id;
        logic [WORD_WIDTH-1:0] hops;
        logic [WORD_WIDTH-1:0] q;
        logic                  valid;
    } nt_best_t;

    localparam nt_best_t BEST_INIT = '{id: NO_NODE, hops: NO_NODE, q: '0, valid: 1'b0};

endpackage

// File: rtl/nt_hop_selector_if.sv
// Neighbor-table read bus between the hop selector (master) and the table memory (slave).
//   rd_en/rd_addr       : read strobe and address, from the selector
//   mSourceID..mEnergyLeft : entry fields, valid the cycle after rd_en
interface nt_hop_selector_if;
    import nt_pkg::*;

    logic                  rd_en;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [WORD_WIDTH-1:0] mSourceID;
    logic [WORD_WIDTH-1:0] mHopsFromCH;
    logic [WORD_WIDTH-1:0] mQValue;
    logic [WORD_WIDTH-1:0] mEnergyLeft;

    modport master (
        output rd_en,
        output rd_addr,
        input  mSourceID,
        input  mHopsFromCH,
        input  mQValue,
        input  mEnergyLeft
    );

    modport slave (
        input  rd_en,
        input  rd_addr,
        output mSourceID,
        output mHopsFromCH,
        output mQValue,
        output mEnergyLeft
    );

endinterface

// File: rtl/nt_hop_selector_cmp.sv
// nt_candidate_cmp: combinational "entry is better than current best" comparator.
//   entry        : table entry under test
//   best         : current best candidate
//   own_hops     : own hop count to CH; a candidate must be strictly closer
//   is_better_c  : entry qualifies and beats best (strict, so lower index wins ties)
// Optional macro NT_ENERGY_FLOOR_EN: also require entry.energy >= ENERGY_FLOOR.
module nt_candidate_cmp
    import nt_pkg::*;
(
    input  nt_entry_t             entry,
    input  nt_best_t              best,
    input  logic [WORD_WIDTH-1:0] own_hops,
    output logic                  is_better_c
);

    logic candidate_c;

`ifdef NT_ENERGY_FLOOR_EN
    assign candidate_c = (entry.hops < own_hops) && (entry.energy >= ENERGY_FLOOR);
`else
    logic unused_energy_c;
    assign unused_energy_c = ^entry.energy;
    assign candidate_c     = (entry.hops < own_hops);
`endif

    // Rank: fewer hops first, then strictly higher Q.
    always_comb begin
        is_better_c = 1'b0;
        if (candidate_c) begin
            is_better_c = !best.valid
                       || (entry.hops < best.hops)
                       || ((entry.hops == best.hops) && (entry.q > best.q));
        end
    end

endmodule

// File: rtl/nt_hop_selector.sv
// nt_hop_selector: scans the neighbor table on request and selects the best next hop
// toward the cluster head (CH-direct > fewer hops > higher Q).
//   clk, rst       : clock, synchronous active-high reset
//   start          : scan request, accepted only when idle
//   HB_Reset       : heartbeat reset, aborts any scan and clears results
//   hopsFromCH, chosenCH, neighborCount : own context, latched at start
//   tbl            : table read bus (master side)
//   nextHop, nextHopCount, nextHopQ, found : registered result, updated with done
//   busy, done     : scan in progress / one-cycle completion pulse
// Optional macro NT_ENERGY_FLOOR_EN: gate candidates on minimum remaining energy.
module nt_hop_selector
    import nt_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  HB_Reset,
    input  logic [WORD_WIDTH-1:0] hopsFromCH,
    input  logic [WORD_WIDTH-1:0] chosenCH,
    input  logic [WORD_WIDTH-1:0] neighborCount,
    nt_hop_selector_if.master     tbl,
    output logic [WORD_WIDTH-1:0] nextHop,
    output logic [WORD_WIDTH-1:0] nextHopCount,
    output logic [WORD_WIDTH-1:0] nextHopQ,
    output logic                  found,
    output logic                  busy,
    output logic                  done
);

    nt_state_t             state_q, state_d;
    logic [WORD_WIDTH-1:0] cnt_q, cnt_d;
    logic [WORD_WIDTH-1:0] own_hops_q, own_hops_d;
    nt_best_t              best_q, best_d;
    logic                  rd_en_q, rd_en_d;
    logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    nt_best_t              result_q, result_d;

    nt_entry_t             entry_c;
    nt_best_t              best_upd_c;
    logic                  is_better_c;
    logic                  cmp_en_c;
    logic [WORD_WIDTH-1:0] count_clamped_c;
    logic                  last_addr_c;

    assign entry_c = '{id:     tbl.mSourceID,
                       hops:   tbl.mHopsFromCH,
                       q:      tbl.mQValue,
                       energy: tbl.mEnergyLeft};

    nt_candidate_cmp u_cmp (
        .entry       (entry_c),
        .best        (best_q),
        .own_hops    (own_hops_q),
        .is_better_c (is_better_c)
    );

    // Read data lags the address by one cycle: nothing to compare on the first scan cycle.
    assign cmp_en_c   = ((state_q == S_SCAN) && (rd_addr_q != '0)) || (state_q == S_DRAIN);
    assign best_upd_c = (cmp_en_c && is_better_c)
                      ? '{id: entry_c.id, hops: entry_c.hops, q: entry_c.q, valid: 1'b1}
                      : best_q;

    assign count_clamped_c = (neighborCount > WORD_WIDTH'(MAX_NEIGHBORS))
                           ? WORD_WIDTH'(MAX_NEIGHBORS) : neighborCount;
    assign last_addr_c     = (WORD_WIDTH'(rd_addr_q) == (cnt_q - WORD_WIDTH'(1)));

    // Next-state and registered-output logic.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        own_hops_d = own_hops_q;
        best_d     = best_q;
        rd_en_d    = 1'b0;
        rd_addr_d  = rd_addr_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        result_d   = result_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    own_hops_d = hopsFromCH;
                    cnt_d      = count_clamped_c;
                    best_d     = BEST_INIT;
                    if (hopsFromCH == WORD_WIDTH'(1)) begin
                        // Cluster head is a direct neighbor.
                        best_d   = '{id: chosenCH, hops: '0, q: NO_NODE, valid: 1'b1};
                        result_d = best_d;
                        done_d   = 1'b1;
                        state_d  = S_DONE;
                    end else if ((hopsFromCH == '0) || (hopsFromCH == NO_NODE)
                                 || (count_clamped_c == '0)) begin
                        result_d = BEST_INIT;
                        done_d   = 1'b1;
                        state_d  = S_DONE;
                    end else begin
                        rd_en_d   = 1'b1;
                        rd_addr_d = '0;
                        busy_d    = 1'b1;
                        state_d   = S_SCAN;
                    end
                end
            end
            S_SCAN: begin
                best_d = best_upd_c;
                if (last_addr_c) begin
                    state_d = S_DRAIN;
                end else begin
                    rd_en_d   = 1'b1;
                    rd_addr_d = rd_addr_q + ADDR_WIDTH'(1);
                end
            end
            S_DRAIN: begin
                best_d   = best_upd_c;
                result_d = best_upd_c;
                done_d   = 1'b1;
                busy_d   = 1'b0;
                state_d  = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Heartbeat reset wins over everything, including a same-cycle start.
        if (HB_Reset) begin
            state_d   = S_IDLE;
            best_d    = BEST_INIT;
            rd_en_d   = 1'b0;
            rd_addr_d = '0;
            busy_d    = 1'b0;
            done_d    = 1'b0;
            result_d  = BEST_INIT;
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            own_hops_q <= '0;
            best_q     <= BEST_INIT;
            rd_en_q    <= 1'b0;
            rd_addr_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            result_q   <= BEST_INIT;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            own_hops_q <= own_hops_d;
            best_q     <= best_d;
            rd_en_q    <= rd_en_d;
            rd_addr_q  <= rd_addr_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            result_q   <= result_d;
        end
    end

    assign tbl.rd_en     = rd_en_q;
    assign tbl.rd_addr   = rd_addr_q;
    assign nextHop       = result_q.id;
    assign nextHopCount  = result_q.hops;
    assign nextHopQ      = result_q.q;
    assign found         = result_q.valid;
    assign busy          = busy_q;
    assign done          = done_q;

endmodule

// File: tb/tb_nt_hop_selector.sv
// Directed testbench for nt_hop_selector with a one-cycle-latency table model.
module tb_nt_hop_selector;
    import nt_pkg::*;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  start;
    logic                  HB_Reset;
    logic [WORD_WIDTH-1:0] hopsFromCH;
    logic [WORD_WIDTH-1:0] chosenCH;
    logic [WORD_WIDTH-1:0] neighborCount;
    logic [WORD_WIDTH-1:0] nextHop;
    logic [WORD_WIDTH-1:0] nextHopCount;
    logic [WORD_WIDTH-1:0] nextHopQ;
    logic                  found;
    logic                  busy;
    logic                  done;

    nt_hop_selector_if bus ();

    nt_hop_selector dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .HB_Reset     (HB_Reset),
        .hopsFromCH   (hopsFromCH),
        .chosenCH     (chosenCH),
        .neighborCount(neighborCount),
        .tbl          (bus),
        .nextHop      (nextHop),
        .nextHopCount (nextHopCount),
        .nextHopQ     (nextHopQ),
        .found        (found),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    logic [15:0] m_id   [16];
    logic [15:0] m_hops [16];
    logic [15:0] m_q    [16];
    logic [15:0] m_en   [16];

    // Table memory: one-cycle read latency.
    always @(posedge clk) begin
        if (bus.rd_en) begin
            bus.mSourceID   <= m_id[bus.rd_addr];
            bus.mHopsFromCH <= m_hops[bus.rd_addr];
            bus.mQValue     <= m_q[bus.rd_addr];
            bus.mEnergyLeft <= m_en[bus.rd_addr];
        end
    end

    int vectors    = 0;
    int miscompares = 0;
    int done_cyc;
    int done_seen;
    bit saw_rd;
    bit saw_busy_done;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 16; i++) begin
            m_id[i]   = 16'h0100 + 16'(i);
            m_hops[i] = 16'hFFFF;
            m_q[i]    = 16'h0000;
            m_en[i]   = 16'd100;
        end
    endtask

    task automatic set_ent(input int i, input logic [15:0] hops, input logic [15:0] q,
                           input logic [15:0] en);
        m_hops[i] = hops;
        m_q[i]    = q;
        m_en[i]   = en;
    endtask

    // Called at a negedge; start sampled at edge "cycle 0"; returns done cycle or -1.
    task automatic run_scan(input logic [15:0] hops, input logic [15:0] ch,
                            input logic [15:0] cnt);
        hopsFromCH    = hops;
        chosenCH      = ch;
        neighborCount = cnt;
        start         = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        done_cyc      = -1;
        saw_rd        = 1'b0;
        saw_busy_done = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (bus.rd_en) saw_rd = 1'b1;
            if (c == 3) start = 1'b1;  // stray start while busy must be ignored
            if (c == 4) start = 1'b0;
            if (done) begin
                done_cyc = c;
                if (busy) saw_busy_done = 1'b1;
                break;
            end
        end
        start = 1'b0;
        @(negedge clk);
        check("done_one_cycle", 32'(done), 32'd0);
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; HB_Reset = 1'b0;
        hopsFromCH = '0; chosenCH = '0; neighborCount = '0;
        clear_mem();
        @(posedge clk);
        @(negedge clk);
        check("rst_nextHop", 32'(nextHop), 32'hFFFF);
        check("rst_nextHopCount", 32'(nextHopCount), 32'hFFFF);
        check("rst_nextHopQ", 32'(nextHopQ), 32'h0);
        check("rst_flags", {28'd0, found, busy, done, bus.rd_en}, 32'h0);
        check("rst_rd_addr", 32'(bus.rd_addr), 32'h0);
        rst = 1'b0;
        @(negedge clk);

        // CH-direct neighbor.
        run_scan(16'd1, 16'h0007, 16'd4);
        check("direct_done_cyc", 32'(done_cyc), 32'd1);
        check("direct_nextHop", 32'(nextHop), 32'h0007);
        check("direct_count", 32'(nextHopCount), 32'h0);
        check("direct_q", 32'(nextHopQ), 32'hFFFF);
        check("direct_found", 32'(found), 32'd1);
        check("direct_no_rd", 32'(saw_rd), 32'd0);

        // Fewer hops first, then higher Q.
        clear_mem();
        set_ent(0, 16'd2, 16'd90, 16'd100);
        set_ent(1, 16'd1, 16'd40, 16'd100);
        set_ent(2, 16'd1, 16'd60, 16'd100);
        set_ent(3, 16'd3, 16'd99, 16'd100);
        run_scan(16'd3, 16'h0007, 16'd4);
        check("scan4_done_cyc", 32'(done_cyc), 32'd6);
        check("scan4_busy_at_done", 32'(saw_busy_done), 32'd0);
        check("scan4_nextHop", 32'(nextHop), 32'h0102);
        check("scan4_count", 32'(nextHopCount), 32'd1);
        check("scan4_q", 32'(nextHopQ), 32'd60);
        check("scan4_found", 32'(found), 32'd1);

        // No entry closer than own hop count.
        clear_mem();
        set_ent(0, 16'd2, 16'd10, 16'd100);
        set_ent(1, 16'd3, 16'd10, 16'd100);
        run_scan(16'd2, 16'h0007, 16'd2);
        check("none_done_cyc", 32'(done_cyc), 32'd4);
        check("none_found", 32'(found), 32'd0);
        check("none_nextHop", 32'(nextHop), 32'hFFFF);
        check("none_count", 32'(nextHopCount), 32'hFFFF);

        // Tie: lower index wins.
        clear_mem();
        set_ent(0, 16'd1, 16'd50, 16'd100);
        set_ent(1, 16'd2, 16'd80, 16'd100);
        set_ent(2, 16'd3, 16'd90, 16'd100);
        set_ent(3, 16'd1, 16'd50, 16'd100);
        run_scan(16'd3, 16'h0007, 16'd4);
        check("tie_nextHop", 32'(nextHop), 32'h0100);
        check("tie_q", 32'(nextHopQ), 32'd50);

        // Empty table and invalid own hop counts.
        run_scan(16'd3, 16'h0007, 16'd0);
        check("empty_done_cyc", 32'(done_cyc), 32'd1);
        check("empty_found", 32'(found), 32'd0);
        check("empty_nextHop", 32'(nextHop), 32'hFFFF);
        run_scan(16'd0, 16'h0007, 16'd4);
        check("hops0_done_cyc", 32'(done_cyc), 32'd1);
        check("hops0_found", 32'(found), 32'd0);
        run_scan(16'hFFFF, 16'h0007, 16'd4);
        check("hopsFFFF_found", 32'(found), 32'd0);
        check("hopsFFFF_no_rd", 32'(saw_rd), 32'd0);

        // Count clamps to 16; best sits in the last entry.
        clear_mem();
        for (int i = 0; i < 16; i++) set_ent(i, 16'd4, 16'(i), 16'd100);
        set_ent(15, 16'd2, 16'd5, 16'd100);
        run_scan(16'd5, 16'h0007, 16'd20);
        check("clamp_done_cyc", 32'(done_cyc), 32'd18);
        check("clamp_nextHop", 32'(nextHop), 32'h010F);
        check("clamp_count", 32'(nextHopCount), 32'd2);

        // HB_Reset in cycle 3 of an 8-entry scan.
        clear_mem();
        for (int i = 0; i < 8; i++) set_ent(i, 16'd2, 16'(10 + i), 16'd100);
        hopsFromCH = 16'd3; neighborCount = 16'd8;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        HB_Reset = 1'b1;
        @(posedge clk);
        #1 HB_Reset = 1'b0;
        done_seen = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (done) done_seen++;
        end
        check("hb_no_done", 32'(done_seen), 32'd0);
        check("hb_nextHop", 32'(nextHop), 32'hFFFF);
        check("hb_count", 32'(nextHopCount), 32'hFFFF);
        check("hb_flags", {29'd0, found, busy, bus.rd_en}, 32'h0);
        run_scan(16'd3, 16'h0007, 16'd8);
        check("hb_rerun_done_cyc", 32'(done_cyc), 32'd10);
        check("hb_rerun_nextHop", 32'(nextHop), 32'h0107);
        check("hb_rerun_q", 32'(nextHopQ), 32'd17);

        // Synchronous reset mid-scan.
        hopsFromCH = 16'd3; neighborCount = 16'd8;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_mid_nextHop", 32'(nextHop), 32'hFFFF);
        check("rst_mid_flags", {28'd0, found, busy, done, bus.rd_en}, 32'h0);

        // Energy floor gating.
        clear_mem();
        set_ent(0, 16'd1, 16'd70, 16'd5);
        set_ent(1, 16'd2, 16'd20, 16'd100);
        run_scan(16'd3, 16'h0007, 16'd2);
`ifdef NT_ENERGY_FLOOR_EN
        check("energy_nextHop", 32'(nextHop), 32'h0101);
        check("energy_count", 32'(nextHopCount), 32'd2);
`else
        check("energy_nextHop", 32'(nextHop), 32'h0100);
        check("energy_count", 32'(nextHopCount), 32'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
